// File: rtl/opc5ls_mem_arbiter.sv
// Two-CPU shared-memory arbiter: grants one port at a time, stretches each
// access by WAIT_STATES cycles and stalls the CPUs through their clock enables.
//
// state  | meaning
// IDLE   | arbitration cycle; requesters stalled, memory bus quiet
// ACCESS | memory driven from granted port; cnt_q counts down the wait states
module opc5ls_mem_arbiter #(
  parameter int WAIT_STATES   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vpa0,
  input  logic        vda0,
  input  logic        rnw0,
  input  logic [15:0] address0,
  input  logic [15:0] dout0,
  input  logic        vpa1,
  input  logic        vda1,
  input  logic        rnw1,
  input  logic [15:0] address1,
  input  logic [15:0] dout1,
  output logic        clken0,
  output logic        clken1,
  output logic [15:0] din0,
  output logic [15:0] din1,
  output logic [15:0] mem_address,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  output logic        mem_we
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] WAIT_CNT = 2'(WAIT_STATES);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] cnt_q, cnt_d;
  logic       req0, req1;
  logic       winner;

  assign req0 = vpa0 | vda0;
  assign req1 = vpa1 | vda1;

  // last_q resets to 1 so the first round-robin tie goes to port 0.
  always_comb begin
    if (req0 && req1) begin
      winner = (PRIORITY_MODE != 0) ? 1'b0 : !last_q;
    end else begin
      winner = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    clken0      = !req0;
    clken1      = !req1;
    mem_address = 16'h0000;
    mem_dout    = 16'h0000;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = winner;
          cnt_d   = WAIT_CNT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_address = grant_q ? address1 : address0;
        mem_dout    = grant_q ? dout1 : dout0;
        mem_we      = grant_q ? !rnw1 : !rnw0;
        if (grant_q) begin
          clken1 = (cnt_q == 2'd0);
        end else begin
          clken0 = (cnt_q == 2'd0);
        end
        if (cnt_q == 2'd0) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset releases both CPUs and silences the memory bus immediately.
    if (reset) begin
      clken0      = 1'b1;
      clken1      = 1'b1;
      mem_address = 16'h0000;
      mem_dout    = 16'h0000;
      mem_we      = 1'b0;
    end
  end

  assign din0 = mem_din;
  assign din1 = mem_din;

endmodule

// File: tb/tb_opc5ls_mem_arbiter.sv
// Bench for opc5ls_mem_arbiter: three parameterisations share one stimulus;
// expected completions are queued per instance and matched on clken pulses.
module tb_opc5ls_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vpa0 = 1'b0, vda0 = 1'b0, rnw0 = 1'b1;
  logic        vpa1 = 1'b0, vda1 = 1'b0, rnw1 = 1'b1;
  logic [15:0] address0 = 16'h0, dout0 = 16'h0;
  logic [15:0] address1 = 16'h0, dout1 = 16'h0;

  logic        clken0_a, clken1_a, mem_we_a;
  logic [15:0] din0_a, din1_a, mem_address_a, mem_dout_a, mem_din_a;
  logic        clken0_b, clken1_b, mem_we_b;
  logic [15:0] din0_b, din1_b, mem_address_b, mem_dout_b, mem_din_b;
  logic        clken0_c, clken1_c, mem_we_c;
  logic [15:0] din0_c, din1_c, mem_address_c, mem_dout_c, mem_din_c;

  logic req0, req1;
  assign req0 = vpa0 | vda0;
  assign req1 = vpa1 | vda1;

  // Memory read data is a fixed scramble of the address.
  assign mem_din_a = mem_address_a ^ 16'hA5A5;
  assign mem_din_b = mem_address_b ^ 16'hA5A5;
  assign mem_din_c = mem_address_c ^ 16'hA5A5;

  always #5 clk = ~clk;

  opc5ls_mem_arbiter #(.WAIT_STATES(1), .PRIORITY_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .vpa0(vpa0), .vda0(vda0), .rnw0(rnw0), .address0(address0), .dout0(dout0),
    .vpa1(vpa1), .vda1(vda1), .rnw1(rnw1), .address1(address1), .dout1(dout1),
    .clken0(clken0_a), .clken1(clken1_a), .din0(din0_a), .din1(din1_a),
    .mem_address(mem_address_a), .mem_dout(mem_dout_a), .mem_din(mem_din_a),
    .mem_we(mem_we_a)
  );

  opc5ls_mem_arbiter #(.WAIT_STATES(1), .PRIORITY_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .vpa0(vpa0), .vda0(vda0), .rnw0(rnw0), .address0(address0), .dout0(dout0),
    .vpa1(vpa1), .vda1(vda1), .rnw1(rnw1), .address1(address1), .dout1(dout1),
    .clken0(clken0_b), .clken1(clken1_b), .din0(din0_b), .din1(din1_b),
    .mem_address(mem_address_b), .mem_dout(mem_dout_b), .mem_din(mem_din_b),
    .mem_we(mem_we_b)
  );

  opc5ls_mem_arbiter #(.WAIT_STATES(0), .PRIORITY_MODE(0)) dut_c (
    .clk(clk), .reset(reset),
    .vpa0(vpa0), .vda0(vda0), .rnw0(rnw0), .address0(address0), .dout0(dout0),
    .vpa1(vpa1), .vda1(vda1), .rnw1(rnw1), .address1(address1), .dout1(dout1),
    .clken0(clken0_c), .clken1(clken1_c), .din0(din0_c), .din1(din1_c),
    .mem_address(mem_address_c), .mem_dout(mem_dout_c), .mem_din(mem_din_c),
    .mem_we(mem_we_c)
  );

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // cyc is 1 in the first cycle after reset is released.
  always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int inst, input int port, input int c,
                         input logic [15:0] addr, input logic we, input logic [15:0] wdata);
    exp_t e;
    e.inst = inst; e.port = port; e.cyc = c;
    e.addr = addr; e.we = we; e.wdata = wdata;
    sb_q.push_back(e);
  endtask

  task automatic mon_port(input int inst, input int p, input logic req, input logic ck,
                          input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input logic [15:0] din);
    int idx;
    if (!req) begin
      check_val($sformatf("i%0d_idle_clken%0d_c%0d", inst, p, cyc), ck, 1);
    end else if (ck) begin
      idx = -1;
      foreach (sb_q[i]) if (idx < 0 && sb_q[i].inst == inst) idx = i;
      check_val($sformatf("i%0d_expected_p%0d_c%0d", inst, p, cyc), 32'(idx >= 0), 1);
      if (idx >= 0) begin
        check_val($sformatf("i%0d_port", inst), p, sb_q[idx].port);
        check_val($sformatf("i%0d_cycle", inst), cyc, sb_q[idx].cyc);
        check_val($sformatf("i%0d_addr", inst), addr, sb_q[idx].addr);
        check_val($sformatf("i%0d_we", inst), we, sb_q[idx].we);
        check_val($sformatf("i%0d_wdata", inst), wdata, sb_q[idx].wdata);
        check_val($sformatf("i%0d_din", inst), din, sb_q[idx].addr ^ 16'hA5A5);
        sb_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_port(0, 0, req0, clken0_a, mem_address_a, mem_we_a, mem_dout_a, din0_a);
      mon_port(0, 1, req1, clken1_a, mem_address_a, mem_we_a, mem_dout_a, din1_a);
      mon_port(1, 0, req0, clken0_b, mem_address_b, mem_we_b, mem_dout_b, din0_b);
      mon_port(1, 1, req1, clken1_b, mem_address_b, mem_we_b, mem_dout_b, din1_b);
      mon_port(2, 0, req0, clken0_c, mem_address_c, mem_we_c, mem_dout_c, din0_c);
      mon_port(2, 1, req1, clken1_c, mem_address_c, mem_we_c, mem_dout_c, din1_c);
    end
  end

  // Called just after a posedge; leaves reset asserted with the state cleared.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    vpa0 = 1'b0; vda0 = 1'b0; rnw0 = 1'b1;
    vpa1 = 1'b0; vda1 = 1'b0; rnw1 = 1'b1;
    address0 = 16'h0; dout0 = 16'h0; address1 = 16'h0; dout1 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: requests and writes active, yet clkens high and bus quiet.
    repeat (2) @(posedge clk);
    #1;
    vpa0 = 1'b1; vda0 = 1'b1; rnw0 = 1'b0; address0 = 16'h1357; dout0 = 16'h2468;
    vpa1 = 1'b1; vda1 = 1'b1; rnw1 = 1'b0; address1 = 16'h9BDF; dout1 = 16'hACE0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_clken0_a", clken0_a, 1);
    check_val("rst_clken1_a", clken1_a, 1);
    check_val("rst_we_a", mem_we_a, 0);
    check_val("rst_addr_a", mem_address_a, 16'h0);
    check_val("rst_clken0_b", clken0_b, 1);
    check_val("rst_clken1_b", clken1_b, 1);
    check_val("rst_we_c", mem_we_c, 0);
    check_val("rst_clken1_c", clken1_c, 1);
    @(posedge clk);

    // Both ports reading continuously: round-robin vs fixed priority.
    do_reset();
    vpa0 = 1'b1; rnw0 = 1'b1; address0 = 16'h1000; dout0 = 16'h1111;
    vpa1 = 1'b1; rnw1 = 1'b1; address1 = 16'h2000; dout1 = 16'h2222;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb_push(0, 0, 3 + 6 * k, 16'h1000, 1'b0, 16'h1111);
      sb_push(0, 1, 6 + 6 * k, 16'h2000, 1'b0, 16'h2222);
    end
    for (int k = 0; k < 4; k++) sb_push(1, 0, 3 + 3 * k, 16'h1000, 1'b0, 16'h1111);
    for (int k = 0; k < 3; k++) begin
      sb_push(2, 0, 2 + 4 * k, 16'h1000, 1'b0, 16'h1111);
      sb_push(2, 1, 4 + 4 * k, 16'h2000, 1'b0, 16'h2222);
    end
    repeat (12) @(posedge clk);
    check_val("rr_sb_empty", sb_q.size(), 0);

    // Single write on port 1.
    do_reset();
    vda1 = 1'b1; rnw1 = 1'b0; address1 = 16'h1234; dout1 = 16'hBEEF;
    reset = 1'b0;
    sb_push(0, 1, 3, 16'h1234, 1'b1, 16'hBEEF);
    sb_push(1, 1, 3, 16'h1234, 1'b1, 16'hBEEF);
    sb_push(2, 1, 2, 16'h1234, 1'b1, 16'hBEEF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_val($sformatf("wr_we_c%0d", k), mem_we_a, 32'(k == 2 || k == 3));
      if (k == 2 || k == 3) begin
        check_val($sformatf("wr_addr_c%0d", k), mem_address_a, 16'h1234);
        check_val($sformatf("wr_dout_c%0d", k), mem_dout_a, 16'hBEEF);
      end else begin
        check_val($sformatf("wr_addr_quiet_c%0d", k), mem_address_a, 16'h0);
      end
      if (k == 2) check_val("wr_clken1_stall", clken1_a, 0);
      @(posedge clk);
      #1;
      if (k == 3) vda1 = 1'b0;
    end
    #1;
    check_val("wr_sb_empty", sb_q.size(), 0);
    @(posedge clk);

    // Port 0 idle while port 1 reads back to back.
    do_reset();
    vpa1 = 1'b1; rnw1 = 1'b1; address1 = 16'h3456; dout1 = 16'h0F0F;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb_push(0, 1, 3 + 3 * k, 16'h3456, 1'b0, 16'h0F0F);
      sb_push(1, 1, 3 + 3 * k, 16'h3456, 1'b0, 16'h0F0F);
    end
    for (int k = 0; k < 4; k++) sb_push(2, 1, 2 + 2 * k, 16'h3456, 1'b0, 16'h0F0F);
    repeat (9) @(posedge clk);
    check_val("idle0_sb_empty", sb_q.size(), 0);

    // Zero wait states: port-0 read returns on the second cycle.
    do_reset();
    vpa0 = 1'b1; rnw0 = 1'b1; address0 = 16'hFFFF; dout0 = 16'h0000;
    reset = 1'b0;
    sb_push(0, 0, 3, 16'hFFFF, 1'b0, 16'h0000);
    sb_push(1, 0, 3, 16'hFFFF, 1'b0, 16'h0000);
    sb_push(2, 0, 2, 16'hFFFF, 1'b0, 16'h0000);
    @(negedge clk);
    check_val("ws0_clken0_c1", clken0_c, 0);
    @(negedge clk);
    check_val("ws0_clken0_c2", clken0_c, 1);
    check_val("ws0_din0_c2", din0_c, 16'h5A5A);
    repeat (2) @(posedge clk);
    check_val("ws0_sb_empty", sb_q.size(), 0);

    // Reset during the first access cycle of a port-0 write.
    do_reset();
    vda0 = 1'b1; rnw0 = 1'b0; address0 = 16'h4321; dout0 = 16'hCAFE;
    reset = 1'b0;
    sb_push(2, 0, 2, 16'h4321, 1'b1, 16'hCAFE);
    @(negedge clk);
    @(negedge clk);
    check_val("abort_we_before", mem_we_a, 1);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_we", mem_we_a, 0);
    check_val("abort_clken0", clken0_a, 1);
    check_val("abort_clken1", clken1_a, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("abort_idle_we", mem_we_a, 0);
    check_val("abort_idle_addr", mem_address_a, 16'h0);
    check_val("abort_idle_clken0", clken0_a, 0);
    check_val("abort_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/opc5ls_mem_arbiter.md
OPC5LS_MEM_ARBITER -- requirements
Module: opc5ls_mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, meaning extra memory cycles per access (0..3).
REQ-002 The block SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority to port 0.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have ports vpa0, vda0, rnw0, input, 1 each, meaning port-0 CPU bus cycle type and direction.
REQ-006 The block SHALL have ports address0 and dout0, input, 16 each, meaning port-0 CPU address and write data.
REQ-007 The block SHALL have ports vpa1, vda1, rnw1, address1 and dout1, matching REQ-005/REQ-006, for port 1.
REQ-008 The block SHALL have ports clken0 and clken1, output, 1 each, meaning per-CPU clock enable (stall when 0).
REQ-009 The block SHALL have ports din0 and din1, output, 16 each, meaning read data returned to each CPU.
REQ-010 The block SHALL have port mem_address, output, 16, meaning the shared memory address.
REQ-011 The block SHALL have ports mem_dout (output, 16) and mem_din (input, 16), meaning memory write data and asynchronous-read data.
REQ-012 The block SHALL have port mem_we, output, 1, meaning active-high memory write strobe.

Function
REQ-013 Port n requests the bus when (vpan | vdan) = 1; a non-requesting port SHALL see clkenn = 1 in every state (internal CPU cycles never stall).
REQ-014 The FSM SHALL have two states, IDLE and ACCESS, plus registers grant_q (1 bit), last_q (1 bit) and cnt_q (2 bits).
REQ-015 In IDLE, if no port requests, the FSM SHALL stay in IDLE with mem_we = 0.
REQ-016 In IDLE with requests: a single requester SHALL win; on a tie, PRIORITY_MODE 0 SHALL grant !last_q, PRIORITY_MODE 1 SHALL grant port 0.
REQ-017 On a win the FSM SHALL load grant_q = winner, cnt_q = WAIT_STATES and move to ACCESS at the next edge.
REQ-018 In IDLE, every requesting port SHALL have clken = 0.
REQ-019 In ACCESS, mem_address and mem_dout SHALL be driven combinationally from the granted port's address/dout.
REQ-020 In ACCESS, mem_we SHALL equal !rnw of the granted port on every cycle of the access.
REQ-021 In ACCESS, cnt_q SHALL decrement each cycle while non-zero.
REQ-022 When cnt_q = 0 in ACCESS: granted clken = 1 for exactly that cycle, last_q <= grant_q, and the FSM returns to IDLE.
REQ-023 The granted port's clken SHALL be 0 on all other ACCESS cycles.
REQ-024 The non-granted port, if requesting, SHALL have clken = 0 throughout ACCESS.
REQ-025 din0 and din1 SHALL both equal mem_din at all times; the CPU samples only when its clken = 1.
REQ-026 Each access SHALL occupy exactly WAIT_STATES + 2 cycles (one IDLE arbitration cycle plus WAIT_STATES + 1 ACCESS cycles).
REQ-027 Outside ACCESS, mem_address SHALL be 0, mem_dout SHALL be 0 and mem_we SHALL be 0.
REQ-028 A change in a requester's vpa/vda while it is stalled is illegal (the CPU holds its state when clken = 0) and need not be handled.
REQ-029 Fairness: in mode 0, neither port SHALL wait more than one other access while both request continuously.

Reset
REQ-030 While reset = 1, the block SHALL hold state = IDLE, grant_q = 0, last_q = 1, cnt_q = 0, mem_we = 0.
REQ-031 While reset = 1, clken0 = clken1 = 1, so that CPU internal reset synchronisers advance.
REQ-032 Reset asserted mid-ACCESS SHALL abort the access at the next edge with no further mem_we and no completion clken.
REQ-033 After reset, in mode 0, the first tie SHALL be granted to port 0.

Verification
REQ-034 Reset, then vpa0 = vpa1 = 1 held (WAIT_STATES = 1) -> port-0 clken0 pulses in cycle 3 and port-1 clken1 pulses in cycle 6; each pulse is 1 cycle wide, and the pattern alternates thereafter.
REQ-035 Write on port 1 only: vda1 = 1, rnw1 = 0, address1 = 0x1234, dout1 = 0xBEEF -> mem_we = 1 for 2 cycles with mem_address = 0x1234 and mem_dout = 0xBEEF; clken1 = 1 on the second cycle; clken0 = 1 throughout.
REQ-036 PRIORITY_MODE = 1 with both ports requesting continuously -> port 0 is granted every access and port 1 never completes while port 0 keeps requesting.
REQ-037 WAIT_STATES = 0, port-0 read with mem_din = 0x5A5A -> clken0 = 1 on the second cycle and din0 = 0x5A5A on that cycle.
REQ-038 Reset asserted during the first ACCESS cycle of a write -> mem_we = 0 and clken0 = clken1 = 1 from the next cycle; state returns to IDLE.
REQ-039 Port 0 idle (vpa0 = vda0 = 0) while port 1 performs accesses -> clken0 = 1 on every cycle.
